// File: rtl/reg_alu_seq.sv
// Instruction sequencer for reg_alu: a 4-deep instruction/immediate FIFO feeding
// a single-issue executor that drives the register-file write beats and latches carry.
module reg_alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_imm,
    output logic        sel,
    output logic        wr,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in,
    input  logic        cout,
    output logic        carry,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CLS_NOP = 2'b00,
        CLS_LDI = 2'b01,
        CLS_ALU = 2'b10,
        CLS_REP = 2'b11
    } class_e;

    // ------------------------------------------------------------------
    // Instruction FIFO: each entry is {instr, imm}
    // ------------------------------------------------------------------
    logic [31:0] fifo_mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic        full, empty, push, pop;

    assign full     = (count_q == 3'd4);
    assign empty    = (count_q == 3'd0);
    assign in_ready = !full;
    // A full FIFO refuses the push even when the executor pops on the same edge.
    assign push     = in_valid && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !reset) fifo_mem_q[wr_ptr_q] <= {in_instr, in_imm};
    end

    // ------------------------------------------------------------------
    // Executor: issue register plus beat counter
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [31:0] issue_q, issue_d;
    logic [2:0]  beat_q, beat_d;
    logic        carry_q;

    class_e      cls;
    logic [2:0]  cnt;
    logic        last_beat;

    assign cls       = class_e'(issue_q[31:30]);
    assign cnt       = issue_q[18:16];
    assign last_beat = (cls != CLS_REP) || (beat_q == cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            issue_q <= 32'd0;
            beat_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            beat_q  <= beat_d;
        end
    end

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        beat_d  = beat_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                    issue_d = fifo_mem_q[rd_ptr_q];
                    beat_d  = 3'd0;
                end
            end
            EXEC: begin
                if (last_beat) begin
                    if (!empty) begin
                        // Back-to-back issue: next instruction loads on the last beat's edge.
                        pop     = 1'b1;
                        issue_d = fifo_mem_q[rd_ptr_q];
                        beat_d  = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // reg_alu controls come only from the issue register, never from the FIFO head.
    always_comb begin
        wr        = 1'b0;
        sel       = 1'b0;
        op        = 2'd0;
        wr_addr   = 3'd0;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        d_in      = 16'd0;
        if (state_q == EXEC) begin
            wr        = (cls != CLS_NOP);
            sel       = (cls == CLS_ALU) || (cls == CLS_REP);
            op        = issue_q[29:28];
            wr_addr   = issue_q[27:25];
            rd_addr_a = issue_q[24:22];
            rd_addr_b = issue_q[21:19];
            d_in      = issue_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else if (wr && sel) begin
            carry_q <= cout;
        end
    end

    assign carry = carry_q;
    assign busy  = (state_q == EXEC) || !empty;

endmodule

// File: tb/tb_reg_alu_seq.sv
// Directed self-checking bench for reg_alu_seq; expected values are hand-derived
// from the instruction format and the issue timing of the sequencer.
module tb_reg_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_imm;
    logic        sel;
    logic        wr;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic        cout;
    logic        carry;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_alu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_imm    (in_imm),
        .sel       (sel),
        .wr        (wr),
        .op        (op),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .cout      (cout),
        .carry     (carry),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] imm);
        in_valid = v;
        in_instr = ins;
        in_imm   = imm;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cout_pat;
        int nops_sent, wr_beats, nop_beats, ready_low, sent_at_first_low, late_wr;

        reset = 1'b1;
        cout  = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        tick();
        tick();

        // Reset state
        check("rst_wr", wr, 0);
        check("rst_sel", sel, 0);
        check("rst_op_addr", {op, wr_addr, rd_addr_a, rd_addr_b}, 0);
        check("rst_d_in", d_in, 0);
        check("rst_carry", carry, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // LDI r5 = 0x1234
        drive(1'b1, 16'h4A00, 16'h1234);
        tick();
        drive(1'b0, 16'h0000, 16'h0000);
        check("ldi_wr_before_pop", wr, 0);
        check("ldi_busy_queued", busy, 1);
        tick();
        check("ldi_wr", wr, 1);
        check("ldi_sel", sel, 0);
        check("ldi_wr_addr", wr_addr, 5);
        check("ldi_d_in", d_in, 16'h1234);
        check("ldi_carry", carry, 0);
        tick();
        check("ldi_wr_after", wr, 0);
        check("ldi_busy_after", busy, 0);

        // Back-to-back: LDI r1=1, LDI r2=2, ALU r1 = r1 op01 r2
        drive(1'b1, 16'h4200, 16'h0001);
        tick();
        check("b2b_gap0_wr", wr, 0);
        drive(1'b1, 16'h4400, 16'h0002);
        tick();
        check("b2b_beat1_wr", wr, 1);
        check("b2b_beat1_fields", {sel, wr_addr, d_in}, {1'b0, 3'd1, 16'h0001});
        drive(1'b1, 16'h9250, 16'h0000);
        tick();
        drive(1'b0, 16'h0000, 16'h0000);
        check("b2b_beat2_wr", wr, 1);
        check("b2b_beat2_fields", {sel, wr_addr, d_in}, {1'b0, 3'd2, 16'h0002});
        tick();
        check("b2b_beat3_wr", wr, 1);
        check("b2b_beat3_sel", sel, 1);
        check("b2b_beat3_op", op, 2'b01);
        check("b2b_beat3_addr", {wr_addr, rd_addr_a, rd_addr_b}, {3'd1, 3'd1, 3'd2});
        cout = 1'b1;
        tick();
        cout = 1'b0;
        check("b2b_done_wr", wr, 0);
        check("alu_carry_set", carry, 1);

        // Carry hold across LDI r3 with cout low
        drive(1'b1, 16'h4600, 16'h0007);
        tick();
        drive(1'b0, 16'h0000, 16'h0000);
        tick();
        check("hold_ldi_wr", {wr, sel, wr_addr}, {1'b1, 1'b0, 3'd3});
        tick();
        check("hold_carry", carry, 1);

        // REP cnt=3: r1 = r1 op01 r2, four beats
        cout_pat = 4'b0111;
        drive(1'b1, 16'hD253, 16'h0000);
        tick();
        drive(1'b0, 16'h0000, 16'h0000);
        check("rep_wr_before_pop", wr, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rep_beat%0d_wr", i), wr, 1);
            check($sformatf("rep_beat%0d_fields", i),
                  {sel, op, wr_addr, rd_addr_a, rd_addr_b},
                  {1'b1, 2'b01, 3'd1, 3'd1, 3'd2});
            if (i == 3) check("rep_carry_before_last", carry, 1);
            cout = cout_pat[i];
        end
        tick();
        cout = 1'b0;
        check("rep_done_wr", wr, 0);
        check("rep_done_busy", busy, 0);
        check("rep_carry_last_beat", carry, 0);

        // Full FIFO: REP cnt=7 then 5 NOPs offered continuously
        drive(1'b1, 16'hD257, 16'h0000);
        tick();
        nops_sent         = 0;
        wr_beats          = 0;
        nop_beats         = 0;
        ready_low         = 0;
        sent_at_first_low = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (nops_sent < 5) drive(1'b1, 16'h0000, 16'h0000);
            else               drive(1'b0, 16'h0000, 16'h0000);
            if (in_valid && in_ready) nops_sent++;
            tick();
            if (wr) wr_beats++;
            else if (busy && wr_beats == 8) nop_beats++;
            if (!in_ready) begin
                ready_low++;
                if (sent_at_first_low < 0) sent_at_first_low = nops_sent;
            end
        end
        check("full_wr_beats", wr_beats, 8);
        check("full_nop_beats", nop_beats, 5);
        check("full_nops_accepted", nops_sent, 5);
        check("full_first_not_ready", sent_at_first_low, 4);
        check("full_ready_low_cycles", ready_low, 5);
        check("full_busy_end", busy, 0);

        // Reset on the 2nd beat of a REP cnt=5 with two LDIs queued
        cout = 1'b1;
        drive(1'b1, 16'hD255, 16'h0000);
        tick();
        drive(1'b1, 16'h4200, 16'h0001);
        tick();
        drive(1'b1, 16'h4400, 16'h0002);
        tick();
        drive(1'b0, 16'h0000, 16'h0000);
        check("midrst_beat2_wr", wr, 1);
        check("midrst_pre_carry", carry, 1);
        check("midrst_pre_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_wr", wr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_carry", carry, 0);
        late_wr = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr) late_wr++;
        end
        check("midrst_no_late_writes", late_wr, 0);
        check("midrst_busy_end", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
